// File: rtl/simple_axi_slave.sv
// Single-beat AXI4 memory slave: DEPTH x 64-bit RAM with independent write and read FSMs.
// Define SIMPLE_AXI_SLAVE_WAIT_EN to insert WAIT_CYCLES idle cycles before bvalid/rvalid.
module simple_axi_slave #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_COLLECT, WR_WAIT, WR_RESP} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_e;

  logic [63:0]   mem_q [DEPTH];
  wr_state_e     wr_state_q;
  rd_state_e     rd_state_q;
  logic          awready_q, wready_q, aw_got_q, w_got_q, aw_err_q, bvalid_q;
  logic [1:0]    bresp_q;
  logic [AW-1:0] aw_idx_q, ar_idx_q;
  logic [63:0]   wdata_q;
  logic [7:0]    wstrb_q;
  logic          arready_q, ar_err_q, rvalid_q, rlast_q;
  logic [7:0]    rd_beats_q;
  logic [63:0]   rdata_q;
  logic [1:0]    rresp_q;
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
  logic [7:0]    wr_wcnt_q, rd_wcnt_q;
`endif

  logic aw_hs, w_hs, ar_hs, wr_commit, aw_oor, ar_oor, unused_ok;

  assign aw_hs     = s_axi_awvalid && awready_q;
  assign w_hs      = s_axi_wvalid && wready_q;
  assign ar_hs     = s_axi_arvalid && arready_q;
  assign aw_oor    = |s_axi_awaddr[31:AW+3];
  assign ar_oor    = |s_axi_araddr[31:AW+3];
  assign wr_commit = (wr_state_q == WR_COLLECT) && aw_got_q && w_got_q && !aw_err_q;
  assign unused_ok = &{1'b0, s_axi_awsize, s_axi_arsize, s_axi_awaddr[2:0],
                       s_axi_araddr[2:0], 8'(WAIT_CYCLES)};

  // Unreset datapath: captured address/data and the RAM itself
  always_ff @(posedge i_clk) begin
    if (aw_hs) aw_idx_q <= s_axi_awaddr[3 +: AW];
    if (w_hs) begin
      wdata_q <= s_axi_wdata;
      wstrb_q <= s_axi_wstrb;
    end
    if (ar_hs) ar_idx_q <= s_axi_araddr[3 +: AW];
    if (wr_commit) begin
      for (int k = 0; k < 8; k++) begin
        if (wstrb_q[k]) mem_q[aw_idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_state_q <= WR_COLLECT;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_err_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
      wr_wcnt_q  <= 8'd0;
`endif
    end else begin
      case (wr_state_q)
        WR_COLLECT: begin
          if (aw_got_q && w_got_q) begin
            bresp_q <= aw_err_q ? RESP_SLVERR : RESP_OKAY;
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
            if (WAIT_CYCLES != 0) begin
              wr_wcnt_q  <= 8'(WAIT_CYCLES);
              wr_state_q <= WR_WAIT;
            end else begin
              bvalid_q   <= 1'b1;
              wr_state_q <= WR_RESP;
            end
`else
            bvalid_q   <= 1'b1;
            wr_state_q <= WR_RESP;
`endif
          end else begin
            if (aw_hs) begin
              aw_got_q  <= 1'b1;
              awready_q <= 1'b0;
              aw_err_q  <= (s_axi_awlen != 8'd0) || aw_oor;
            end else if (!aw_got_q) begin
              awready_q <= 1'b1;
            end
            // Error bursts still drain every W beat; only wlast closes collection
            if (w_hs) begin
              if (s_axi_wlast) begin
                w_got_q  <= 1'b1;
                wready_q <= 1'b0;
              end
            end else if (!w_got_q) begin
              wready_q <= 1'b1;
            end
          end
        end
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
        WR_WAIT: begin
          if (wr_wcnt_q <= 8'd1) begin
            bvalid_q   <= 1'b1;
            wr_state_q <= WR_RESP;
          end else begin
            wr_wcnt_q <= wr_wcnt_q - 8'd1;
          end
        end
`endif
        WR_RESP: begin
          if (s_axi_bready && bvalid_q) begin
            bvalid_q   <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= WR_COLLECT;
          end
        end
        default: wr_state_q <= WR_COLLECT;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      ar_err_q   <= 1'b0;
      rd_beats_q <= 8'd0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 64'd0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
      rd_wcnt_q  <= 8'd0;
`endif
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs) begin
            arready_q  <= 1'b0;
            ar_err_q   <= (s_axi_arlen != 8'd0) || ar_oor;
            rd_beats_q <= s_axi_arlen;
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
            if (WAIT_CYCLES != 0) begin
              rd_wcnt_q  <= 8'(WAIT_CYCLES);
              rd_state_q <= RD_WAIT;
            end else begin
              rd_state_q <= RD_DATA;
            end
`else
            rd_state_q <= RD_DATA;
`endif
          end else begin
            arready_q <= 1'b1;
          end
        end
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
        RD_WAIT: begin
          if (rd_wcnt_q <= 8'd1) rd_state_q <= RD_DATA;
          else rd_wcnt_q <= rd_wcnt_q - 8'd1;
        end
`endif
        RD_DATA: begin
          // Each beat is loaded one cycle after entry or after the previous handshake
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= ar_err_q ? 64'd0 : mem_q[ar_idx_q];
            rresp_q  <= ar_err_q ? RESP_SLVERR : RESP_OKAY;
            rlast_q  <= (rd_beats_q == 8'd0);
          end else if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            if (rd_beats_q == 8'd0) begin
              arready_q  <= 1'b1;
              rd_state_q <= RD_IDLE;
            end else begin
              rd_beats_q <= rd_beats_q - 8'd1;
            end
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
endmodule

// File: tb/tb_simple_axi_slave.sv
// Directed bench for simple_axi_slave; response latency follows SIMPLE_AXI_SLAVE_WAIT_EN.
module tb_simple_axi_slave;
  localparam int DEPTH = 256;
  localparam int WAITC = 2;
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
  localparam int LAT = 1 + WAITC;
`else
  localparam int LAT = 1;
`endif

  logic        clk, rst;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [63:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;

  int n_chk = 0;
  int n_fail = 0;

  simple_axi_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .i_clk(clk), .i_rst(rst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rlast(rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] outs();
    return 80'({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast});
  endfunction

  task automatic wait_b(input string tag);
    int n = 0;
    while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_blat"}, 80'(n), 80'(LAT));
  endtask

  task automatic wait_r(input string tag);
    int n = 0;
    while (rvalid !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_rlat"}, 80'(n), 80'(LAT));
  endtask

  task automatic write_tx(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic [1:0] exp_resp, input string tag);
    awaddr = a; awlen = 8'd0; awvalid = 1'b1;
    wdata = d; wstrb = s; wlast = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, "_rdy_drop"}, 80'({awready, wready}), 80'(2'b00));
    wait_b(tag);
    tick();
    chk({tag, "_bhold"}, 80'({bvalid, bresp}), 80'({1'b1, exp_resp}));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({tag, "_bdone"}, 80'({bvalid, awready, wready}), 80'(3'b011));
  endtask

  task automatic read_tx(input logic [31:0] a, input logic [63:0] exp_d,
                         input logic [1:0] exp_resp, input string tag);
    araddr = a; arlen = 8'd0; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk({tag, "_ardrop"}, 80'(arready), 80'(0));
    wait_r(tag);
    chk({tag, "_rdata"}, 80'(rdata), 80'(exp_d));
    chk({tag, "_rresp"}, 80'({rresp, rlast}), 80'({exp_resp, 1'b1}));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk({tag, "_rdone"}, 80'({rvalid, arready}), 80'(2'b01));
  endtask

  initial begin
    rst = 1'b1;
    awvalid = 0; awaddr = 0; awlen = 0; awsize = 3'd3;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arlen = 0; arsize = 3'd3; rready = 0;
    repeat (2) tick();
    chk("reset_outs", outs(), 80'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 80'({awready, wready, arready}), 80'(3'b111));

    // AW and W in the same cycle, full strobe
    write_tx(32'h0, 64'h1122334455667788, 8'hFF, 2'b00, "t1_wr");
    read_tx(32'h0, 64'h1122334455667788, 2'b00, "t1_rd");

    // W two cycles ahead of AW, low-half strobe
    write_tx(32'h8, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b00, "t2_fill");
    wdata = 64'h00000000DEADBEEF; wstrb = 8'h0F; wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t2_w_first", 80'({wready, awready}), 80'(2'b01));
    tick();
    chk("t2_no_b_yet", 80'(bvalid), 80'(0));
    awaddr = 32'h8; awlen = 8'd0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wait_b("t2_wr");
    chk("t2_bresp", 80'(bresp), 80'(2'b00));
    bready = 1'b1; tick(); bready = 1'b0;
    read_tx(32'h8, 64'hFFFFFFFFDEADBEEF, 2'b00, "t2_rd");

    // AW first, then W with upper-half strobe
    awaddr = 32'h8; awlen = 8'd0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t2b_aw_first", 80'({awready, wready}), 80'(2'b01));
    wdata = 64'h12345678_00000000; wstrb = 8'hF0; wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    wait_b("t2b_wr");
    bready = 1'b1; tick(); bready = 1'b0;
    read_tx(32'h8, 64'h12345678DEADBEEF, 2'b00, "t2b_rd");

    // Out-of-range write is rejected and leaves RAM untouched
    write_tx(DEPTH * 8, 64'hAA, 8'hFF, 2'b10, "t3_oor");
    read_tx(32'h0, 64'h1122334455667788, 2'b00, "t3_rd0");

    // Two-beat burst read: SLVERR, zero data, rlast only on the final beat
    araddr = 32'h0; arlen = 8'd1; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    wait_r("t4_b0");
    chk("t4_beat0", 80'({rdata, rresp, rlast}), 80'({64'd0, 2'b10, 1'b0}));
    repeat (3) begin
      tick();
      chk("t4_hold", 80'({rvalid, rdata, rresp, rlast}), 80'({1'b1, 64'd0, 2'b10, 1'b0}));
    end
    rready = 1'b1; tick(); rready = 1'b0;
    chk("t4_gap", 80'(rvalid), 80'(0));
    tick();
    chk("t4_beat1", 80'({rvalid, rdata, rresp, rlast}), 80'({1'b1, 64'd0, 2'b10, 1'b1}));
    rready = 1'b1; tick(); rready = 1'b0;
    chk("t4_done", 80'({rvalid, arready}), 80'(2'b01));

    // Reset while bvalid is high
    awaddr = 32'h18; awlen = 8'd0; awvalid = 1'b1;
    wdata = 64'h5555555555555555; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b("t6a");
    rst = 1'b1;
    #1;
    chk("t6a_reset_outs", outs(), 80'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6a_ready", 80'({awready, wready, arready}), 80'(3'b111));

    // Reset between the W and AW handshakes discards the pending write
    write_tx(32'h10, 64'h0123456789ABCDEF, 8'hFF, 2'b00, "t6b_init");
    wdata = 64'hFFFFFFFFFFFFFFFF; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6b_reset_outs", outs(), 80'd0);
    tick();
    rst = 1'b0;
    tick();
    read_tx(32'h10, 64'h0123456789ABCDEF, 2'b00, "t6b_rd");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
